fft_stage_feeder: RTL

//   Frame buffer and operand sequencer directly upstream of the radix-2 butterfly. Collects one
//   N-point frame of complex samples, then issues N/2 (a, b, twiddle index) pairs for one DIT stage.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_pair_addr_gen.sv | 34 +++
 rtl/fft_stage_feeder.sv | 99 +++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage feeder: complex sample layout,
// feeder state encoding and a constant-foldable log2.
package fft_pkg;

    localparam int FFT_DATA_WIDTH = 12;

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] im;
    } complex_t;

    typedef enum logic {
        FILL  = 1'b0,
        ISSUE = 1'b1
    } fft_state_e;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int fft_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pair_addr_gen.sv
// Maps a pair counter to the DIT butterfly operand addresses and twiddle index
// for one fixed stage. Purely combinational.
module fft_pair_addr_gen
    import fft_pkg::*;
#(
    parameter  int N_POINTS = 16,
    parameter  int STAGE    = 0,
    localparam int LOG2N    = fft_log2(N_POINTS)
) (
    input  logic [LOG2N-2:0] pair_cnt,
    output logic [LOG2N-1:0] a_idx,
    output logic [LOG2N-1:0] b_idx,
    output logic [LOG2N-2:0] tw_idx,
    output logic             last
);

    localparam int SPAN = 1 << STAGE;

    logic [LOG2N-1:0] k_w;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-2:0] j;

    always_comb begin
        k_w   = {1'b0, pair_cnt};
        j     = pair_cnt & (LOG2N-1)'(SPAN - 1);
        grp   = k_w >> STAGE;
        // Group g starts at g*2*span; the span bit of a_idx is always clear.
        a_idx = (grp << (STAGE + 1)) | {1'b0, j};
        b_idx = a_idx | LOG2N'(SPAN);
        tw_idx = j << (LOG2N - 1 - STAGE);
        last  = (pair_cnt == {(LOG2N-1){1'b1}});
    end

endmodule

// File: rtl/fft_stage_feeder.sv
// Frame buffer plus operand sequencer feeding a radix-2 butterfly: fills an
// N-sample frame, then issues N/2 (a, b, twiddle index) pairs for one DIT stage.
module fft_stage_feeder
    import fft_pkg::*;
#(
    parameter  int DATA_WIDTH = 12,
    parameter  int N_POINTS   = 16,
    parameter  int STAGE      = 0,
    localparam int LOG2N      = fft_log2(N_POINTS),
    localparam int CW         = 2 * DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fdr_ready_in,
    input  logic             fdr_valid_in,
    input  logic [CW-1:0]    fdr_data_in,
    input  logic             fdr_ready_out,
    output logic             fdr_valid_out,
    output logic [CW-1:0]    fdr_a_out,
    output logic [CW-1:0]    fdr_b_out,
    output logic [LOG2N-2:0] fdr_tw_idx,
    output logic             fdr_last_out
);

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    fft_state_e       state, state_nx;
    logic [LOG2N-1:0] wr_cnt, wr_cnt_nx;
    logic [LOG2N-2:0] pair_cnt, pair_cnt_nx;
    logic             wr_en;
    logic             pair_last;
    logic [LOG2N-1:0] a_idx, b_idx;

    cplx_t sample_buf [N_POINTS];

    fft_pair_addr_gen #(
        .N_POINTS (N_POINTS),
        .STAGE    (STAGE)
    ) u_addr (
        .pair_cnt (pair_cnt),
        .a_idx    (a_idx),
        .b_idx    (b_idx),
        .tw_idx   (fdr_tw_idx),
        .last     (pair_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FILL;
            wr_cnt   <= '0;
            pair_cnt <= '0;
        end else begin
            state    <= state_nx;
            wr_cnt   <= wr_cnt_nx;
            pair_cnt <= pair_cnt_nx;
        end
    end

    // Frame storage needs no reset; a partial frame is simply overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) sample_buf[wr_cnt] <= cplx_t'(fdr_data_in);
    end

    always_comb begin
        state_nx      = state;
        wr_cnt_nx     = wr_cnt;
        pair_cnt_nx   = pair_cnt;
        fdr_ready_in  = 1'b0;
        fdr_valid_out = 1'b0;
        wr_en         = 1'b0;
        case (state)
            FILL: begin
                fdr_ready_in = 1'b1;
                wr_en        = fdr_valid_in;
                if (wr_en) begin
                    wr_cnt_nx = wr_cnt + 1'b1;
                    if (wr_cnt == LOG2N'(N_POINTS - 1)) state_nx = ISSUE;
                end
            end
            ISSUE: begin
                fdr_valid_out = 1'b1;
                if (fdr_ready_out) begin
                    pair_cnt_nx = pair_cnt + 1'b1;
                    if (pair_last) state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
        fdr_last_out = fdr_valid_out & pair_last;
    end

    // Operands come straight from registered state, so they hold under backpressure.
    assign fdr_a_out = sample_buf[a_idx];
    assign fdr_b_out = sample_buf[b_idx];

endmodule
